ascon_spi_ctrl: RTL and testbench
=================================

// Module: ascon_spi_ctrl
// PURPOSE
//  SPI (mode 0) slave front-end placed directly upstream of the ascon core.
//  Decodes byte-framed host transactions into the key/text/AD registers
//  (reg0/1/2_128b), the operation_mode register and a one-cycle
//  operation_ready launch pulse. Writes to S_0..S_4 go bit-serially via the
//  core's state_shift_* port. All five state words are readable over MISO.
//  SPI pins are oversampled in the clk domain; f_clk >= 4*f_sclk.
// PARAMETERS
//  SYNC_STAGES  2   synchroniser depth on spi_sclk/spi_cs_n/spi_mosi (>=2)
// PORTS
//  clk              in   1    system clock
//  rst_n            in   1    async active-low reset
//  spi_sclk         in   1    SPI clock (asynchronous to clk)
//  spi_cs_n         in   1    SPI chip select, active low
//  spi_mosi         in   1    SPI data in
//  spi_miso         out  1    SPI data out
//  core_busy        in   1    ascon core not in IDLE_STATE
//  S_0_reg..S_4_reg in   64ea state readback from core
//  reg0_128b        out  128  key register
//  reg1_128b        out  128  text register
//  reg2_128b        out  128  associated-data register
//  operation_mode   out  3    IDLE/ENCRYPT/DECRYPT/HASH/XOF/CXOF code
//  operation_ready  out  1    one-cycle launch pulse
//  state_shift_en   out  1    one-cycle pulse per state bit written
//  state_shift_sel  out  3    target state word 0..4
//  state_shift_lsb  out  1    bit shifted into LSB of selected word
// BEHAVIOUR
//  Async reset, all outputs: regs 0, mode 3'b000, ready/shift_en/lsb 0,
//   sel 0, miso 0, FSM IDLE.
//  Sync: SYNC_STAGES flops per pin; rise/fall detect on synced sclk.
//   Sample mosi on sclk rise; update miso on sclk fall. Pin-to-action latency:
//   SYNC_STAGES+1 clk.
//  Frame: cmd byte MSB first: [7]=RnW, [6:4] ignored, [3:0]=addr, then
//   payload MSB first. Map: 0-2 reg0-2 (128b), 3 ctrl (8b), 4-8 S_0-S_4 (64b).
//   Addr 9-15: payload ignored, reads return 0.
//  Ctrl write byte: [2:0] mode, [7] start. Read: {core_busy,4'b0,mode}.
//  FSM: IDLE -(cs fall)-> CMD -(8th bit)-> WDATA|RDATA -(len bits)-> DONE.
//   cs_n rise in any state -> IDLE next cycle. Bits after len ignored
//   in DONE; miso held 0.
//  Bit counter 8b: 0..127 for 128b, 0..63 for state words, 0..7 for ctrl.
//  reg0-2 writes: 128b shadow shift reg, committed in the cycle after the
//   128th bit; partial frame (cs_n rise early) discards with no commit.
//  Ctrl write commits mode on 8th payload bit; if start=1, operation_ready
//   pulses the same cycle as the commit and the new mode is already visible.
//  State writes are not atomic: each sampled bit -> state_shift_en=1 for
//   exactly one clk with sel=addr-4, lsb=bit. Early cs_n rise leaves the word
//   partially shifted (documented host error).
//  core_busy=1 at commit/bit time: reg/ctrl/state writes dropped silently,
//   no ready pulse. Reads always allowed; S_x sampled at end of cmd byte.
//  Read: at the 8th cmd bit, load the selected value left-aligned into the
//   shadow reg. MSB appears on miso at the next sclk fall, then shifts.
//  cs_n fall while rst_n low: ignored. Reset mid-frame: abort, no commit.
// STRUCTURE
//  Shared pkg/defines: operation mode codes (match core), SPI addr map
//  constants, FSM state encodings.
//  Sub-module spi_pin_sync: SYNC_STAGES synchroniser + sclk edge detect,
//  instantiated once for sclk, cs_n and mosi.
// TESTING
//  Write addr0 with 0x000102..0F -> reg0_128b==128'h000102030405060708090A0B0C0D0E0F
//   one clk after the 128th bit; reg1/reg2 unchanged.
//  Write ctrl 0x81, core_busy=0 -> mode==3'b001 and one operation_ready pulse.
//   Repeat with core_busy=1 -> no pulse, mode unchanged.
//  Write addr4 with 64'hDEADBEEF_01234567 -> exactly 64 shift_en pulses,
//   sel==0, lsb sequence matches MSB-first bits.
//  Read addr6 with S_2_reg=64'hA5A5_0000_FFFF_1234 -> miso bits match MSB
//   first; ctrl read with busy=1, mode=3 -> 0x83.
//  Abort addr1 write after 100 bits (cs_n rise) -> reg1 unchanged; next full
//   frame accepted normally.
//  Assert rst_n low mid-read -> all outputs at reset values; first frame after
//   release is decoded correctly.

Source files
------------

// File: rtl/ascon_spi_ctrl_pkg.sv
// Shared definitions for the ascon SPI front-end: operation codes, register
// map, FSM encoding and the per-address payload length.
package ascon_spi_ctrl_pkg;

    typedef enum logic [2:0] {
        MODE_IDLE    = 3'd0,
        MODE_ENCRYPT = 3'd1,
        MODE_DECRYPT = 3'd2,
        MODE_HASH    = 3'd3,
        MODE_XOF     = 3'd4,
        MODE_CXOF    = 3'd5
    } op_mode_e;

    localparam logic [3:0] ADDR_REG0 = 4'd0;
    localparam logic [3:0] ADDR_REG1 = 4'd1;
    localparam logic [3:0] ADDR_REG2 = 4'd2;
    localparam logic [3:0] ADDR_CTRL = 4'd3;
    localparam logic [3:0] ADDR_S0   = 4'd4;
    localparam logic [3:0] ADDR_S1   = 4'd5;
    localparam logic [3:0] ADDR_S2   = 4'd6;
    localparam logic [3:0] ADDR_S3   = 4'd7;
    localparam logic [3:0] ADDR_S4   = 4'd8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_WDATA = 3'd2,
        ST_RDATA = 3'd3,
        ST_DONE  = 3'd4
    } spi_state_e;

    // Unmapped addresses still consume one byte before the frame goes quiet.
    function automatic logic [7:0] payload_len(input logic [3:0] addr);
        if (addr <= ADDR_REG2) return 8'd128;
        if (addr == ADDR_CTRL) return 8'd8;
        if (addr <= ADDR_S4)   return 8'd64;
        return 8'd8;
    endfunction

endpackage

// File: rtl/ascon_spi_ctrl_if.sv
// SPI pin bundle between the host (master) and the ascon front-end (slave).
interface ascon_spi_ctrl_if;
    logic spi_sclk;
    logic spi_cs_n;
    logic spi_mosi;
    logic spi_miso;

    modport master (output spi_sclk, output spi_cs_n, output spi_mosi, input spi_miso);
    modport slave  (input spi_sclk, input spi_cs_n, input spi_mosi, output spi_miso);
endinterface

// File: rtl/ascon_spi_ctrl_spi_pin_sync.sv
// Multi-flop synchroniser for one SPI pin with rise/fall detection on the
// synchronised value.
module spi_pin_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_o = sync_q[SYNC_STAGES-1];
    assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign fall_o = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/ascon_spi_ctrl.sv
// SPI mode-0 slave that loads the ascon key/text/AD registers, the operation
// mode, shifts state words bit-serially and reads state back over MISO.
module ascon_spi_ctrl
    import ascon_spi_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    ascon_spi_ctrl_if.slave spi,
    input  logic            core_busy,
    input  logic [63:0]     S_0_reg,
    input  logic [63:0]     S_1_reg,
    input  logic [63:0]     S_2_reg,
    input  logic [63:0]     S_3_reg,
    input  logic [63:0]     S_4_reg,
    output logic [127:0]    reg0_128b,
    output logic [127:0]    reg1_128b,
    output logic [127:0]    reg2_128b,
    output logic [2:0]      operation_mode,
    output logic            operation_ready,
    output logic            state_shift_en,
    output logic [2:0]      state_shift_sel,
    output logic            state_shift_lsb
);

    logic sclk_sync, sclk_rise, sclk_fall;
    logic cs_sync, cs_rise, cs_fall;
    logic mosi_sync, mosi_rise, mosi_fall;
    logic unused_sync;

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .pin_i(spi.spi_sclk),
        .sync_o(sclk_sync), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );

    // cs_n comes out of reset looking asserted so a select already low when
    // reset is released never produces a fall and cannot start a frame.
    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_cs (
        .clk(clk), .rst_n(rst_n), .pin_i(spi.spi_cs_n),
        .sync_o(cs_sync), .rise_o(cs_rise), .fall_o(cs_fall)
    );

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst_n(rst_n), .pin_i(spi.spi_mosi),
        .sync_o(mosi_sync), .rise_o(mosi_rise), .fall_o(mosi_fall)
    );

    assign unused_sync = ^{sclk_sync, cs_sync, mosi_rise, mosi_fall};

    spi_state_e   state_q;
    logic [7:0]   bit_cnt_q;
    logic [6:0]   cmd_q;
    logic [3:0]   addr_q;
    logic [127:0] shadow_q;
    logic         commit_q;
    logic [127:0] reg0_q, reg1_q, reg2_q;
    logic [2:0]   mode_q;
    logic         ready_q, shift_en_q, shift_lsb_q, miso_q;
    logic [2:0]   shift_sel_q;

    logic [7:0]   cmd_d;
    logic [7:0]   ctrl_byte_d;
    logic [7:0]   bit_cnt_d;
    logic [127:0] shadow_d;
    logic [127:0] rd_value;
    logic         last_bit;
    logic         is_state_addr;

    assign cmd_d         = {cmd_q, mosi_sync};
    assign ctrl_byte_d   = {shadow_q[6:0], mosi_sync};
    assign bit_cnt_d     = bit_cnt_q + 8'd1;
    assign shadow_d      = {shadow_q[126:0], mosi_sync};
    assign last_bit      = (bit_cnt_q == payload_len(addr_q) - 8'd1);
    assign is_state_addr = (addr_q >= ADDR_S0) && (addr_q <= ADDR_S4);

    // Read data is captured left-aligned so MISO always shifts out of bit 127.
    always_comb begin
        rd_value = '0;
        case (cmd_d[3:0])
            ADDR_REG0: rd_value = reg0_q;
            ADDR_REG1: rd_value = reg1_q;
            ADDR_REG2: rd_value = reg2_q;
            ADDR_CTRL: rd_value = {core_busy, 4'b0000, mode_q, 120'd0};
            ADDR_S0:   rd_value = {S_0_reg, 64'd0};
            ADDR_S1:   rd_value = {S_1_reg, 64'd0};
            ADDR_S2:   rd_value = {S_2_reg, 64'd0};
            ADDR_S3:   rd_value = {S_3_reg, 64'd0};
            ADDR_S4:   rd_value = {S_4_reg, 64'd0};
            default:   rd_value = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            cmd_q       <= '0;
            addr_q      <= '0;
            shadow_q    <= '0;
            commit_q    <= 1'b0;
            reg0_q      <= '0;
            reg1_q      <= '0;
            reg2_q      <= '0;
            mode_q      <= MODE_IDLE;
            ready_q     <= 1'b0;
            shift_en_q  <= 1'b0;
            shift_sel_q <= '0;
            shift_lsb_q <= 1'b0;
            miso_q      <= 1'b0;
        end else begin
            ready_q    <= 1'b0;
            shift_en_q <= 1'b0;
            commit_q   <= 1'b0;

            // A completed 128-bit frame lands one cycle after its last bit.
            if (commit_q && !core_busy) begin
                case (addr_q)
                    ADDR_REG0: reg0_q <= shadow_q;
                    ADDR_REG1: reg1_q <= shadow_q;
                    ADDR_REG2: reg2_q <= shadow_q;
                    default: ;
                endcase
            end

            if (cs_rise) begin
                state_q <= ST_IDLE;
                miso_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (cs_fall) begin
                            state_q   <= ST_CMD;
                            bit_cnt_q <= '0;
                        end
                    end
                    ST_CMD: begin
                        if (sclk_rise) begin
                            cmd_q     <= cmd_d[6:0];
                            bit_cnt_q <= bit_cnt_d;
                            if (bit_cnt_q == 8'd7) begin
                                addr_q    <= cmd_d[3:0];
                                bit_cnt_q <= '0;
                                if (cmd_d[7]) begin
                                    shadow_q <= rd_value;
                                    state_q  <= ST_RDATA;
                                end else begin
                                    state_q  <= ST_WDATA;
                                end
                            end
                        end
                    end
                    ST_WDATA: begin
                        if (sclk_rise) begin
                            shadow_q  <= shadow_d;
                            bit_cnt_q <= bit_cnt_d;
                            if (is_state_addr && !core_busy) begin
                                shift_en_q  <= 1'b1;
                                shift_sel_q <= 3'(addr_q - ADDR_S0);
                                shift_lsb_q <= mosi_sync;
                            end
                            if (last_bit) begin
                                state_q <= ST_DONE;
                                if (addr_q <= ADDR_REG2) commit_q <= 1'b1;
                                if (addr_q == ADDR_CTRL && !core_busy) begin
                                    mode_q  <= ctrl_byte_d[2:0];
                                    ready_q <= ctrl_byte_d[7];
                                end
                            end
                        end
                    end
                    ST_RDATA: begin
                        if (sclk_fall) begin
                            miso_q   <= shadow_q[127];
                            shadow_q <= {shadow_q[126:0], 1'b0};
                        end
                        if (sclk_rise) begin
                            bit_cnt_q <= bit_cnt_d;
                            if (last_bit) begin
                                state_q <= ST_DONE;
                                miso_q  <= 1'b0;
                            end
                        end
                    end
                    ST_DONE: ;
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign reg0_128b       = reg0_q;
    assign reg1_128b       = reg1_q;
    assign reg2_128b       = reg2_q;
    assign operation_mode  = mode_q;
    assign operation_ready = ready_q;
    assign state_shift_en  = shift_en_q;
    assign state_shift_sel = shift_sel_q;
    assign state_shift_lsb = shift_lsb_q;
    assign spi.spi_miso    = miso_q;

endmodule

// File: tb/tb_ascon_spi_ctrl.sv
// Bench for ascon_spi_ctrl: directed vector table, reset sequence and random
// frames checked against a register-level model of the host-visible map.
module tb_ascon_spi_ctrl;
    import ascon_spi_ctrl_pkg::*;

    localparam int HALF = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ascon_spi_ctrl_if spi_if();

    logic         core_busy;
    logic [63:0]  s_reg [5];
    logic [127:0] reg0, reg1, reg2;
    logic [2:0]   mode;
    logic         ready, sh_en, sh_lsb;
    logic [2:0]   sh_sel;

    ascon_spi_ctrl #(.SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .spi(spi_if), .core_busy(core_busy),
        .S_0_reg(s_reg[0]), .S_1_reg(s_reg[1]), .S_2_reg(s_reg[2]),
        .S_3_reg(s_reg[3]), .S_4_reg(s_reg[4]),
        .reg0_128b(reg0), .reg1_128b(reg1), .reg2_128b(reg2),
        .operation_mode(mode), .operation_ready(ready),
        .state_shift_en(sh_en), .state_shift_sel(sh_sel), .state_shift_lsb(sh_lsb)
    );

    int n_checks = 0;
    int n_pass   = 0;

    int         ready_cnt = 0;
    logic [3:0] shq[$];
    always @(negedge clk) begin
        if (ready) ready_cnt++;
        if (sh_en) shq.push_back({sh_sel, sh_lsb});
    end

    // Host-visible model: three 128-bit registers and the mode field.
    logic [127:0] m_reg [3];
    logic [2:0]   m_mode;

    function automatic int plen(input int a);
        if (a <= 2) return 128;
        if (a == 3) return 8;
        if (a <= 8) return 64;
        return 8;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic spi_bit(input logic b, output logic m);
        spi_if.spi_mosi = b;
        repeat (HALF) @(negedge clk);
        spi_if.spi_sclk = 1'b1;
        m = spi_if.spi_miso;
        repeat (HALF) @(negedge clk);
        spi_if.spi_sclk = 1'b0;
    endtask

    task automatic spi_frame(input logic [7:0] cmd, input int nbits,
                             input logic [127:0] wdata, output logic [127:0] rdata);
        logic m;
        rdata = '0;
        spi_if.spi_cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < 8; i++) spi_bit(cmd[7-i], m);
        for (int i = 0; i < nbits; i++) begin
            spi_bit(wdata[127-i], m);
            rdata[127-i] = m;
        end
        repeat (HALF) @(negedge clk);
        spi_if.spi_cs_n = 1'b1;
        repeat (2*HALF) @(negedge clk);
    endtask

    task automatic do_frame(input string name, input logic rnw, input logic [3:0] addr,
                            input int nbits, input logic [127:0] data, input logic busy,
                            output logic [127:0] obs);
        int a, rbase, sbase, exp_ready, got_sh, bad;
        logic [127:0] exp_rd, rdata;
        logic [3:0]   exp_sh[$];
        logic [63:0]  lsb_pack;
        a = int'(addr);
        core_busy = busy;
        exp_rd = '0;
        if (a <= 2)      exp_rd = m_reg[a];
        else if (a == 3) exp_rd = {busy, 4'b0000, m_mode, 120'd0};
        else if (a <= 8) exp_rd = {s_reg[a-4], 64'd0};
        exp_ready = 0;
        if (!rnw && !busy) begin
            if (a >= 4 && a <= 8)
                for (int i = 0; i < nbits && i < 64; i++) exp_sh.push_back({3'(a-4), data[127-i]});
            if (nbits >= plen(a)) begin
                if (a <= 2) m_reg[a] = data;
                else if (a == 3) begin
                    m_mode    = data[122:120];
                    exp_ready = int'(data[127]);
                end
            end
        end
        rbase = ready_cnt;
        sbase = shq.size();
        spi_frame({rnw, 3'b000, addr}, nbits, data, rdata);
        got_sh = shq.size() - sbase;
        lsb_pack = '0;
        bad = 0;
        for (int i = 0; i < got_sh; i++) begin
            lsb_pack = {lsb_pack[62:0], shq[sbase+i][0]};
            if (i < exp_sh.size() && shq[sbase+i] !== exp_sh[i]) bad++;
        end
        if (rnw) check({name, "_miso"}, rdata, exp_rd);
        check({name, "_reg0"}, reg0, m_reg[0]);
        check({name, "_reg1"}, reg1, m_reg[1]);
        check({name, "_reg2"}, reg2, m_reg[2]);
        check({name, "_mode"}, 128'(mode), 128'(m_mode));
        check({name, "_ready"}, 128'(ready_cnt - rbase), 128'(exp_ready));
        if (!rnw) begin
            check({name, "_nshift"}, 128'(got_sh), 128'(exp_sh.size()));
            check({name, "_shseq_bad"}, 128'(bad), 128'd0);
        end
        obs = '0;
        if (rnw)         obs = rdata;
        else if (a == 0) obs = reg0;
        else if (a == 1) obs = reg1;
        else if (a == 2) obs = reg2;
        else if (a == 3) obs[3:0] = {1'(ready_cnt - rbase), mode};
        else if (a <= 8) begin
            obs[71:64] = 8'(got_sh);
            obs[63:0]  = lsb_pack;
        end
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_reg0"}, reg0, '0);
        check({name, "_reg1"}, reg1, '0);
        check({name, "_reg2"}, reg2, '0);
        check({name, "_mode"}, 128'(mode), 128'(MODE_IDLE));
        check({name, "_ready"}, 128'(ready), '0);
        check({name, "_shen"}, 128'(sh_en), '0);
        check({name, "_shsel"}, 128'(sh_sel), '0);
        check({name, "_shlsb"}, 128'(sh_lsb), '0);
        check({name, "_miso"}, 128'(spi_if.spi_miso), '0);
    endtask

    typedef struct {
        logic         rnw;
        logic [3:0]   addr;
        int           nbits;
        logic         busy;
        logic [127:0] data;
        logic [127:0] exp;
    } vec_t;

    vec_t tv [15];

    initial begin
        #800000;
        $display("FAIL watchdog: time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] obs;
        logic [7:0]   rdcmd;
        logic         m;

        tv[0]  = '{1'b0, 4'd0,  128, 1'b0, 128'h000102030405060708090A0B0C0D0E0F, 128'h000102030405060708090A0B0C0D0E0F};
        tv[1]  = '{1'b0, 4'd3,  8,   1'b0, {8'h81, 120'd0}, 128'({1'b1, MODE_ENCRYPT})};
        tv[2]  = '{1'b0, 4'd3,  8,   1'b1, {8'h82, 120'd0}, 128'({1'b0, MODE_ENCRYPT})};
        tv[3]  = '{1'b0, 4'd4,  64,  1'b0, {64'hDEADBEEF01234567, 64'd0}, {56'd0, 8'd64, 64'hDEADBEEF01234567}};
        tv[4]  = '{1'b0, 4'd7,  64,  1'b1, {64'hFFFF0000AAAA5555, 64'd0}, 128'd0};
        tv[5]  = '{1'b1, 4'd6,  64,  1'b0, 128'd0, {64'hA5A50000FFFF1234, 64'd0}};
        tv[6]  = '{1'b0, 4'd3,  8,   1'b0, {8'h03, 120'd0}, 128'({1'b0, MODE_HASH})};
        tv[7]  = '{1'b1, 4'd3,  16,  1'b1, 128'd0, {8'h83, 120'd0}};
        tv[8]  = '{1'b1, 4'd0,  128, 1'b0, 128'd0, 128'h000102030405060708090A0B0C0D0E0F};
        tv[9]  = '{1'b0, 4'd1,  100, 1'b0, 128'h1111222233334444555566667777888F, 128'd0};
        tv[10] = '{1'b0, 4'd1,  128, 1'b0, 128'hCAFEF00D0123456789ABCDEF55AA33CC, 128'hCAFEF00D0123456789ABCDEF55AA33CC};
        tv[11] = '{1'b0, 4'd2,  128, 1'b1, 128'h0F0F0F0F0F0F0F0F0F0F0F0F0F0F0F0F, 128'd0};
        tv[12] = '{1'b0, 4'd10, 8,   1'b0, {8'hFF, 120'd0}, 128'd0};
        tv[13] = '{1'b1, 4'd13, 8,   1'b0, 128'd0, 128'd0};
        tv[14] = '{1'b0, 4'd8,  64,  1'b0, {64'h0123456789ABCDEF, 64'd0}, {56'd0, 8'd64, 64'h0123456789ABCDEF}};

        spi_if.spi_cs_n = 1'b1;
        spi_if.spi_sclk = 1'b0;
        spi_if.spi_mosi = 1'b0;
        core_busy = 1'b0;
        for (int j = 0; j < 5; j++) s_reg[j] = {$urandom, $urandom};
        s_reg[2] = 64'hA5A50000FFFF1234;
        for (int j = 0; j < 3; j++) m_reg[j] = '0;
        m_mode = MODE_IDLE;

        repeat (5) @(negedge clk);
        check_reset_outputs("in_reset");
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check_reset_outputs("after_reset");

        for (int i = 0; i < 15; i++) begin
            do_frame($sformatf("vec%0d", i), tv[i].rnw, tv[i].addr, tv[i].nbits,
                     tv[i].data, tv[i].busy, obs);
            check($sformatf("vec%0d_obs", i), obs, tv[i].exp);
        end

        // Reset asserted in the middle of a read of S_2.
        core_busy = 1'b0;
        rdcmd = 8'h86;
        spi_if.spi_cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < 8; i++) spi_bit(rdcmd[7-i], m);
        for (int i = 0; i < 20; i++) spi_bit(1'b0, m);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("mid_read_rst");
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check_reset_outputs("rst_release");
        spi_if.spi_cs_n = 1'b1;
        repeat (2*HALF) @(negedge clk);
        for (int j = 0; j < 3; j++) m_reg[j] = '0;
        m_mode = MODE_IDLE;
        do_frame("post_rst_w", 1'b0, 4'd2, 128, 128'h89ABCDEF0011223344556677DEADBEEF, 1'b0, obs);
        check("post_rst_w_obs", obs, 128'h89ABCDEF0011223344556677DEADBEEF);
        do_frame("post_rst_r", 1'b1, 4'd2, 128, 128'd0, 1'b0, obs);
        check("post_rst_r_obs", obs, 128'h89ABCDEF0011223344556677DEADBEEF);

        for (int k = 0; k < 25; k++) begin
            logic [3:0]   ra;
            logic         rrnw, rbusy;
            logic [127:0] rd;
            ra    = 4'($urandom_range(0, 15));
            rrnw  = 1'($urandom_range(0, 1));
            rbusy = ($urandom_range(0, 3) == 0);
            rd    = {$urandom, $urandom, $urandom, $urandom};
            for (int j = 0; j < 5; j++) s_reg[j] = {$urandom, $urandom};
            do_frame($sformatf("rnd%0d", k), rrnw, ra, plen(int'(ra)), rd, rbusy, obs);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
